subleq_loader: RTL and testbench

- Boot-time program loader upstream of the subleq core and its 8192x32 program memory.
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and writes them to consecutive memory addresses from 0.
- Holds the core in reset until a complete, valid image has been written. After release, the core starts with IP = 0.

---
 rtl/subleq_loader_if.sv | 14 +
 rtl/subleq_loader.sv | 144 ++++++++++++++
 tb/tb_subleq_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/subleq_loader_if.sv
// Byte-stream input and program-memory write bus of the subleq boot loader.
// master = UART/memory side, slave = loader.
interface subleq_loader_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  iRxValid;
  logic [7:0]            iRxByte;
  logic [ADDR_WIDTH-1:0] oAddress;
  logic [31:0]           oData;
  logic                  oWren;

  modport master (output iRxValid, iRxByte, input oAddress, oData, oWren);
  modport slave  (input iRxValid, iRxByte, output oAddress, oData, oWren);
endinterface

// File: rtl/subleq_loader.sv
// Boot loader: length-prefixed little-endian image from UART into program memory,
// holding the core in reset until done. Optional trailing XOR checksum: SUBLEQ_LOADER_CHECKSUM_EN.
module subleq_loader #(
  parameter int ADDR_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                iClock,
  input  logic                iReset,
  subleq_loader_if.slave      bus,
  output logic                oCpuReset,
  output logic                oDone,
  output logic                oError,
  output logic [ADDR_WIDTH:0] oWordCount
);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;
  localparam state_t S_FINAL = S_CHECK;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;
  localparam logic [31:0] IDLE_LOAD = 32'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  wren_q, wren_d;
  logic [31:0]           idle_q, idle_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           word_next;
  logic                  accept;
  logic                  idle_run;
  logic                  in_check;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    count_d    = count_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    idle_d     = idle_q;
    csum_d     = csum_q;
    in_check   = 1'b0;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    in_check   = (state_q == S_CHECK);
`endif
    word_next  = {bus.iRxByte, shift_q[31:8]};
    accept     = bus.iRxValid && (state_q == S_LEN || state_q == S_DATA);
    // byte_idx != 0 in S_LEN means a load has started
    idle_run   = (state_q == S_LEN && byte_idx_q != 2'd0) || state_q == S_DATA || in_check;

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = word_next;
      csum_d     = csum_q ^ bus.iRxByte;
    end

    case (state_q)
      S_LEN: begin
        if (accept && byte_idx_q == 2'd3) begin
          len_d = word_next[ADDR_WIDTH:0];
          if (word_next == 32'd0)
            state_d = S_FINAL;
          else if ({1'b0, word_next} > MAX_WORDS)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_idx_q == 2'd3) begin
          wren_d  = 1'b1;
          addr_d  = count_q[ADDR_WIDTH-1:0];
          data_d  = word_next;
          count_d = count_q + 1'b1;
          if (count_d == len_q)
            state_d = S_FINAL;
        end
      end
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.iRxValid)
          state_d = (bus.iRxByte == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: ;
    endcase

    // a byte in the terminal-count cycle reloads the timer instead of timing out
    if (bus.iRxValid)
      idle_d = IDLE_LOAD;
    else if (TIMEOUT_CYCLES != 0 && idle_run) begin
      if (idle_q <= 32'd1)
        state_d = S_ERROR;
      else
        idle_d = idle_q - 32'd1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= S_LEN;
      byte_idx_q <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      idle_q     <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      idle_q     <= idle_d;
      csum_q     <= csum_d;
    end
  end

  assign bus.oAddress = addr_q;
  assign bus.oData    = data_q;
  assign bus.oWren    = wren_q;
  assign oWordCount   = count_q;
  assign oCpuReset    = (state_q != S_DONE);
  assign oDone        = (state_q == S_DONE);
  assign oError       = (state_q == S_ERROR);

endmodule

// File: tb/tb_subleq_loader.sv
// Directed bench for subleq_loader (TIMEOUT_CYCLES = 16); honours SUBLEQ_LOADER_CHECKSUM_EN.
module tb_subleq_loader;
  localparam int AW = 13;

  logic          iClock = 1'b0;
  logic          iReset = 1'b1;
  logic          oCpuReset, oDone, oError;
  logic [AW:0]   oWordCount;

  subleq_loader_if #(.ADDR_WIDTH(AW)) bus ();

  subleq_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .bus        (bus.slave),
    .oCpuReset  (oCpuReset),
    .oDone      (oDone),
    .oError     (oError),
    .oWordCount (oWordCount)
  );

  always #5 iClock = ~iClock;

  int          vectors     = 0;
  int          miscompares = 0;
  int          wr_n        = 0;
  int          wr_snap;
  logic [AW-1:0] wr_addr [16];
  logic [31:0]   wr_data [16];
  logic [7:0]    img [12];

  always @(negedge iClock) begin
    if (bus.oWren) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = bus.oAddress;
        wr_data[wr_n] = bus.oData;
      end
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClock);
      #1;
    end
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    bus.iRxValid = 1'b0;
    tick(2);
    iReset = 1'b0;
    wr_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.iRxValid = 1'b1;
    bus.iRxByte  = b;
    tick(1);
    bus.iRxValid = 1'b0;
  endtask

  initial begin
    bus.iRxValid = 1'b0;
    bus.iRxByte  = 8'h00;
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // reset state
    do_reset();
    check("rst_cpureset", oCpuReset, 1);
    check("rst_done", oDone, 0);
    check("rst_error", oError, 0);
    check("rst_wren", bus.oWren, 0);
    check("rst_count", oWordCount, 0);
    check("rst_addr", bus.oAddress, 0);
    check("rst_data", bus.oData, 0);

    // two-word load, back-to-back bytes
    for (int i = 0; i < 12; i++) begin
      send_byte(img[i]);
      if (i == 7) begin
        check("w0_latency_wren", bus.oWren, 1);
        check("w0_latency_addr", bus.oAddress, 0);
        check("w0_latency_data", bus.oData, 32'h00000003);
        check("w0_latency_count", oWordCount, 1);
      end
    end
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    check("pre_csum_done", oDone, 0);
    send_byte(8'h01);
`endif
    tick(2);
    check("load2_writes", wr_n, 2);
    check("load2_addr0", wr_addr[0], 0);
    check("load2_data0", wr_data[0], 32'h00000003);
    check("load2_addr1", wr_addr[1], 1);
    check("load2_data1", wr_data[1], 32'hFFFFFFFF);
    check("load2_done", oDone, 1);
    check("load2_cpureset", oCpuReset, 0);
    check("load2_count", oWordCount, 2);
    check("load2_error", oError, 0);

    // bytes after done are ignored
    wr_snap = wr_n;
    for (int i = 0; i < 8; i++) send_byte(8'h5A + 8'(i));
    tick(2);
    check("post_done_writes", wr_n, wr_snap);
    check("post_done_done", oDone, 1);
    check("post_done_cpureset", oCpuReset, 0);
    check("post_done_count", oWordCount, 2);
    check("post_done_addr", bus.oAddress, 1);
    check("post_done_data", bus.oData, 32'hFFFFFFFF);
    check("post_done_error", oError, 0);

    // oversize length 8193
    do_reset();
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    check("oversize_error", oError, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    tick(2);
    check("oversize_writes", wr_n, 0);
    check("oversize_cpureset", oCpuReset, 1);
    check("oversize_sticky", oError, 1);

    // maximum length 8192 is accepted
    do_reset();
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    tick(1);
    check("maxlen_error", oError, 0);
    check("maxlen_done", oDone, 0);

    // zero-length image
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    tick(1);
    check("zero_done", oDone, 1);
    check("zero_writes", wr_n, 0);
    check("zero_count", oWordCount, 0);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    // bad checksum: words written, core held
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(img[i]);
    send_byte(8'h00);
    tick(2);
    check("badcsum_writes", wr_n, 2);
    check("badcsum_error", oError, 1);
    check("badcsum_cpureset", oCpuReset, 1);
    check("badcsum_done", oDone, 0);
`endif

    // timeout after length byte 2
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    tick(15);
    check("to_before_limit", oError, 0);
    tick(1);
    check("to_at_limit", oError, 1);

    // byte on the limit cycle wins
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    tick(15);
    send_byte(8'h00);
    check("to_byte_wins", oError, 0);
    send_byte(8'h00);
    tick(3);
    check("to_continue", oError, 0);

    // reset mid-load, then a one-word load
    do_reset();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    check("midrst_count", oWordCount, 0);
    check("midrst_cpureset", oCpuReset, 1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    send_byte(8'h01);
`endif
    tick(2);
    check("midrst_writes", wr_n, 1);
    check("midrst_addr", wr_addr[0], 0);
    check("midrst_data", wr_data[0], 32'hAABBCCDD);
    check("midrst_final_count", oWordCount, 1);
    check("midrst_done", oDone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
